// File: rtl/hamming_pkg.sv
// Hamming(7,4) shared constants and codec helper functions.
// Bit p of a codeword (p = index + 1): p1 p2 d0 p4 d1 d2 d3.
package hamming_pkg;

  localparam int DATA_W = 4;
  localparam int CODE_W = 7;

  function automatic logic [CODE_W-1:0] hamming_encode(
    input logic [DATA_W-1:0] d
  );
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  function automatic logic [2:0] hamming_syndrome(
    input logic [CODE_W-1:0] c
  );
    logic s1, s2, s4;
    s1 = c[0] ^ c[2] ^ c[4] ^ c[6];
    s2 = c[1] ^ c[2] ^ c[5] ^ c[6];
    s4 = c[3] ^ c[4] ^ c[5] ^ c[6];
    return {s4, s2, s1};
  endfunction

  function automatic logic [DATA_W-1:0] hamming_extract(
    input logic [CODE_W-1:0] c
  );
    return {c[6], c[5], c[4], c[2]};
  endfunction

endpackage

// File: rtl/hamming_decoder.sv
// Combinational Hamming(7,4) syndrome, single-bit correction and
// data extraction.
module hamming_decoder
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] rx,
  output logic [CODE_W-1:0] corr,
  output logic [DATA_W-1:0] dec,
  output logic              got
);

  logic [2:0]        syn;
  logic [CODE_W-1:0] one;
  logic [CODE_W-1:0] flip;

  // Syndrome names the 1-based position in error; zero means clean.
  always_comb begin
    one  = CODE_W'(1);
    syn  = hamming_syndrome(rx);
    flip = '0;
    if (syn != 3'd0)
      flip = one << (syn - 3'd1);
    corr = rx ^ flip;
    dec  = hamming_extract(corr);
    got  = (syn != 3'd0);
  end

endmodule

// File: rtl/hamming_codec.sv
// Two-stage registered Hamming(7,4) encode -> channel -> decode.
// Define HAMMING_ERR_INJECT_EN to let err_pos flip one channel bit.
module hamming_codec
  import hamming_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [2:0]        err_pos,
  output logic [CODE_W-1:0] data_encoded,
  output logic [CODE_W-1:0] data_out,
  output logic [DATA_W-1:0] data_dec,
  output logic              data_got,
  output logic              out_valid
);

`ifdef HAMMING_ERR_INJECT_EN
  localparam bit INJECT_EN = 1'b1;
`else
  localparam bit INJECT_EN = 1'b0;
`endif

  logic [2:0]        err_q;
  logic              v1;
  logic [CODE_W-1:0] rx;
  logic [CODE_W-1:0] one;
  logic [CODE_W-1:0] corr;
  logic [DATA_W-1:0] dec;
  logic              got;

  // Stage 1: encode and capture error position on valid input.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_encoded <= '0;
      err_q        <= '0;
      v1           <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        data_encoded <= hamming_encode(data_in);
        err_q        <= err_pos;
      end
    end
  end

  // Channel model: optionally flip the bit at 1-based err_q.
  always_comb begin
    one = CODE_W'(1);
    rx  = data_encoded;
    if (INJECT_EN && err_q != 3'd0)
      rx = data_encoded ^ (one << (err_q - 3'd1));
  end

  hamming_decoder u_dec (
    .rx   (rx),
    .corr (corr),
    .dec  (dec),
    .got  (got)
  );

  // Stage 2: register corrected word; qualified by out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      data_dec  <= '0;
      data_got  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      data_out  <= corr;
      data_dec  <= dec;
      data_got  <= got;
      out_valid <= v1;
    end
  end

endmodule

// File: tb/tb_hamming_codec.sv
// Directed self-checking bench for hamming_codec.
// Expectations follow HAMMING_ERR_INJECT_EN as the RTL build does.
module tb_hamming_codec;

`ifdef HAMMING_ERR_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] data_in;
  logic [2:0] err_pos;
  logic [6:0] data_encoded;
  logic [6:0] data_out;
  logic [3:0] data_dec;
  logic       data_got;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  hamming_codec dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .data_in      (data_in),
    .err_pos      (err_pos),
    .data_encoded (data_encoded),
    .data_out     (data_out),
    .data_dec     (data_dec),
    .data_got     (data_got),
    .out_valid    (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] nib [6];
  logic [6:0] cw  [6];
  logic       pat [10];
  logic [6:0] last_cw;
  logic       prev_v;

  initial begin
    nib[0] = 4'b0101; cw[0] = 7'b0101101;
    nib[1] = 4'b1101; cw[1] = 7'b1100110;
    nib[2] = 4'b1001; cw[2] = 7'b1001100;
    nib[3] = 4'b0110; cw[3] = 7'b0110011;
    nib[4] = 4'b0001; cw[4] = 7'b0000111;
    nib[5] = 4'b0111; cw[5] = 7'b0110100;
    pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 0;
    pat[5] = 0; pat[6] = 1; pat[7] = 0; pat[8] = 0; pat[9] = 0;

    rst = 1'b1; in_valid = 1'b0; data_in = '0; err_pos = '0;
    step();
    step();
    chk("rst_enc", 32'(data_encoded), 0);
    chk("rst_out", 32'(data_out), 0);
    chk("rst_dec", 32'(data_dec), 0);
    chk("rst_got", 32'(data_got), 0);
    chk("rst_vld", 32'(out_valid), 0);

    // Clean pipelined stream, one nibble per cycle
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        in_valid = 1'b1;
        data_in  = nib[i];
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i < 6) chk("enc", 32'(data_encoded), 32'(cw[i]));
      if (i >= 1 && i <= 6) begin
        chk("out", 32'(data_out), 32'(cw[i-1]));
        chk("dec", 32'(data_dec), 32'(nib[i-1]));
        chk("got0", 32'(data_got), 0);
        chk("vld", 32'(out_valid), 1);
      end
    end
    chk("vld_idle", 32'(out_valid), 0);

    // Single-bit correction at position 3
    in_valid = 1'b1; data_in = 4'b0101; err_pos = 3'd3;
    step();
    in_valid = 1'b0; err_pos = 3'd0;
    step();
    chk("cor_out", 32'(data_out), 32'h2D);
    chk("cor_dec", 32'(data_dec), 32'h5);
    chk("cor_got", 32'(data_got), 32'(INJ));
    chk("cor_vld", 32'(out_valid), 1);

    // Sweep every nibble against every error position
    for (int d = 0; d < 16; d++) begin
      for (int e = 0; e < 8; e++) begin
        in_valid = 1'b1; data_in = 4'(d); err_pos = 3'(e);
        step();
        in_valid = 1'b0; err_pos = 3'd0;
        step();
        chk("sw_dec", 32'(data_dec), 32'(d));
        chk("sw_got", 32'(data_got), 32'(INJ && e != 0));
      end
    end

    // Gapped traffic: out_valid tracks in_valid, encoder holds
    last_cw = cw[5];
    in_valid = 1'b1; data_in = nib[5];
    step();
    prev_v = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = pat[i];
      data_in  = nib[i % 6];
      step();
      if (pat[i]) last_cw = cw[i % 6];
      chk("gap_enc", 32'(data_encoded), 32'(last_cw));
      chk("gap_vld", 32'(out_valid), 32'(prev_v));
      prev_v = pat[i];
    end

    // Reset while data is in flight
    in_valid = 1'b1; data_in = nib[1];
    step();
    data_in = nib[2];
    step();
    rst = 1'b1;
    step();
    chk("mrst_vld", 32'(out_valid), 0);
    chk("mrst_out", 32'(data_out), 0);
    chk("mrst_enc", 32'(data_encoded), 0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("mrst_vld1", 32'(out_valid), 0);
    chk("mrst_out1", 32'(data_out), 0);
    step();
    chk("mrst_vld2", 32'(out_valid), 0);
    chk("mrst_enc2", 32'(data_encoded), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
